steer_en: RTL and testbench

Rider-presence and steering-enable qualifier for the Segway datapath. Takes raw left/right load-cell readings, keeps a 4-sample running average per side, and runs a three-state FSM with a ~1.34 s stability timer. Produces `en_steer` and `rider_off`, which feed `balance_cntrl` directly and gate steering and motor output there.

---
 rtl/segway_pkg.sv | 24 ++
 rtl/ld_avg4.sv | 38 +++
 rtl/steer_en.sv | 124 ++++++++++++
 tb/tb_steer_en.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/segway_pkg.sv
// Shared types and constants for the Segway steering-enable datapath.
//   steer_state_t       : rider qualifier FSM states
//   MIN_RIDER_WT_DEF    : default rider-weight threshold on summed average load
//   WT_HYSTERESIS_DEF   : default hysteresis band around the threshold
//   TMR_W_FULL/FAST     : stability timer widths (silicon / fast simulation)
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } steer_state_t;

    localparam logic [11:0] MIN_RIDER_WT_DEF  = 12'h200;
    localparam logic [11:0] WT_HYSTERESIS_DEF = 12'h040;

    localparam int unsigned TMR_W_FULL = 26;
    localparam int unsigned TMR_W_FAST = 15;

    localparam int unsigned LD_W  = 12;
    localparam int unsigned SUM_W = 14;
    localparam int unsigned TOT_W = 13;

endpackage

// File: rtl/ld_avg4.sv
// Four-sample running average of one load cell.
//   clk, rst : clock, synchronous active-high reset
//   ld_vld   : strobe, ld is a new sample this cycle
//   ld       : 12-bit unsigned load sample
//   avg      : 12-bit running average (sum of last 4 samples >> 2), registered
module ld_avg4
    import segway_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_vld,
    input  logic [LD_W-1:0] ld,
    output logic [LD_W-1:0] avg
);

    logic [LD_W-1:0]  hist [4];
    logic [SUM_W-1:0] sum;

    // History shift and running sum; 14 bits hold 4 x 0xFFF exactly, so
    // the modular add/subtract never loses information.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                hist[i] <= '0;
            end
            sum <= '0;
        end else if (ld_vld) begin
            hist[0] <= ld;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            hist[3] <= hist[2];
            sum     <= sum + SUM_W'(ld) - SUM_W'(hist[3]);
        end
    end

    assign avg = sum[SUM_W-1:2];

endmodule

// File: rtl/steer_en.sv
// Rider-presence and steering-enable qualifier.
//   clk, rst        : 50 MHz clock, synchronous active-high reset
//   ld_vld          : strobe, lft_ld / rght_ld valid this cycle
//   lft_ld, rght_ld : 12-bit unsigned load-cell samples
//   en_steer        : rider stably balanced, steering allowed (registered)
//   rider_off       : no rider detected (registered)
module steer_en
    import segway_pkg::*;
#(
    parameter bit          fast_sim      = 1'b0,
    parameter logic [11:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
    parameter logic [11:0] WT_HYSTERESIS = WT_HYSTERESIS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_vld,
    input  logic [LD_W-1:0] lft_ld,
    input  logic [LD_W-1:0] rght_ld,
    output logic            en_steer,
    output logic            rider_off
);

    localparam logic [TOT_W-1:0] THR_HI = TOT_W'(MIN_RIDER_WT) + TOT_W'(WT_HYSTERESIS);
    localparam logic [TOT_W-1:0] THR_LO = TOT_W'(MIN_RIDER_WT) - TOT_W'(WT_HYSTERESIS);

    logic [LD_W-1:0]       avg_l;
    logic [LD_W-1:0]       avg_r;
    logic [TOT_W-1:0]      tot;
    logic [LD_W-1:0]       dif;
    logic                  sum_gt_min;
    logic                  sum_lt_min;
    logic                  diff_gt_1_4;
    logic                  diff_gt_15_16;
    logic [TMR_W_FULL-1:0] tmr;
    logic                  tmr_full;
    logic                  clr_tmr;
    steer_state_t          state;
    steer_state_t          nxt;

    ld_avg4 u_avg_l (
        .clk    (clk),
        .rst    (rst),
        .ld_vld (ld_vld),
        .ld     (lft_ld),
        .avg    (avg_l)
    );

    ld_avg4 u_avg_r (
        .clk    (clk),
        .rst    (rst),
        .ld_vld (ld_vld),
        .ld     (rght_ld),
        .avg    (avg_r)
    );

    // Load comparators on the averaged readings.
    always_comb begin
        tot           = TOT_W'(avg_l) + TOT_W'(avg_r);
        dif           = (avg_l >= avg_r) ? (avg_l - avg_r) : (avg_r - avg_l);
        sum_gt_min    = (tot >= THR_HI);
        sum_lt_min    = (tot < THR_LO);
        diff_gt_1_4   = (TOT_W'(dif) > (tot >> 2));
        diff_gt_15_16 = (TOT_W'(dif) > (tot - (tot >> 4)));
    end

    // Free-running stability timer; wraps silently, only WAIT looks at it.
    always_ff @(posedge clk) begin
        if (rst || clr_tmr) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TMR_W_FULL'(1);
        end
    end

    assign tmr_full = fast_sim ? (&tmr[TMR_W_FAST-1:0]) : (&tmr);

    // State register and outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
        end else begin
            state     <= nxt;
            en_steer  <= (nxt == STEER);
            rider_off <= (nxt == IDLE);
        end
    end

    // Next-state logic; a dismount outranks every other condition.
    always_comb begin
        nxt     = state;
        clr_tmr = 1'b0;
        case (state)
            IDLE: begin
                if (sum_gt_min) begin
                    nxt     = WAIT;
                    clr_tmr = 1'b1;
                end
            end
            WAIT: begin
                if (sum_lt_min) begin
                    nxt = IDLE;
                end else if (diff_gt_1_4) begin
                    clr_tmr = 1'b1;
                end else if (tmr_full) begin
                    nxt = STEER;
                end
            end
            STEER: begin
                if (sum_lt_min) begin
                    nxt = IDLE;
                end else if (diff_gt_15_16) begin
                    nxt     = WAIT;
                    clr_tmr = 1'b1;
                end
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_steer_en.sv
// Directed bench for steer_en with the short (fast_sim) stability timer.
module tb_steer_en;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_vld;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    int errors = 0;
    int checks = 0;
    int k_en;
    int k_ro;

    always #5 clk = ~clk;

    steer_en #(
        .fast_sim (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_vld    (ld_vld),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a load pair as 4 strobes 8 cycles apart (edges 0,8,16,24) and run
    // n edges, recording the first edge index at which each output changed.
    task automatic track(input logic [11:0] l, input logic [11:0] r, input int n);
        logic en0;
        logic ro0;
        en0     = en_steer;
        ro0     = rider_off;
        k_en    = -1;
        k_ro    = -1;
        lft_ld  = l;
        rght_ld = r;
        for (int k = 0; k < n; k++) begin
            ld_vld = ((k % 8) == 0) && (k < 32);
            tick();
            if (k_en < 0 && en_steer !== en0) k_en = k;
            if (k_ro < 0 && rider_off !== ro0) k_ro = k;
        end
        ld_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        ld_vld  = 1'b1;
        lft_ld  = 12'hFFF;
        rght_ld = 12'hFFF;
        tick();
        tick();
        checks++;
        if (en_steer !== 1'b0) begin
            errors++;
            $display("FAIL reset_en: got %b expected 0", en_steer);
        end
        checks++;
        if (rider_off !== 1'b1) begin
            errors++;
            $display("FAIL reset_ro: got %b expected 1", rider_off);
        end
        rst    = 1'b0;
        ld_vld = 1'b0;
        tick();
        tick();
        checks++;
        if (rider_off !== 1'b1) begin
            errors++;
            $display("FAIL reset_hist_clear_ro: got %b expected 1", rider_off);
        end
    endtask

    // Averages 0x60,0xC0,0x120 per side: tot reaches 0x240 on the 3rd strobe.
    task automatic test_mount();
        track(12'h180, 12'h180, 32800);
        checks++;
        if (k_ro !== 17) begin
            errors++;
            $display("FAIL mount_ro_fall_edge: got %0d expected 17", k_ro);
        end
        checks++;
        if (k_en !== 32785) begin
            errors++;
            $display("FAIL mount_en_rise_edge: got %0d expected 32785", k_en);
        end
        checks++;
        if (en_steer !== 1'b1 || rider_off !== 1'b0) begin
            errors++;
            $display("FAIL mount_final: got en=%b ro=%b expected en=1 ro=0", en_steer, rider_off);
        end
    endtask

    // Only the 4th average (0x3C0/0x000) exceeds dif > tot - tot/16 = 0x384.
    task automatic test_step_off();
        track(12'h3C0, 12'h000, 40);
        checks++;
        if (k_en !== 25) begin
            errors++;
            $display("FAIL stepoff_en_fall_edge: got %0d expected 25", k_en);
        end
        checks++;
        if (k_ro !== -1 || rider_off !== 1'b0) begin
            errors++;
            $display("FAIL stepoff_ro: got change=%0d ro=%b expected change=-1 ro=0", k_ro, rider_off);
        end
    endtask

    task automatic test_unbalanced();
        track(12'h300, 12'h080, 1000);
        checks++;
        if (k_en !== -1 || en_steer !== 1'b0) begin
            errors++;
            $display("FAIL unbal_en: got change=%0d en=%b expected change=-1 en=0", k_en, en_steer);
        end
        checks++;
        if (k_ro !== -1 || rider_off !== 1'b0) begin
            errors++;
            $display("FAIL unbal_ro: got change=%0d ro=%b expected change=-1 ro=0", k_ro, rider_off);
        end
    endtask

    // From 0x300/0x080: dif stays > tot/4 through the 2nd strobe, so the
    // last timer clear lands on edge 16 and STEER follows 32768 edges later.
    task automatic test_timer_restart();
        track(12'h180, 12'h180, 32800);
        checks++;
        if (k_en !== 32784) begin
            errors++;
            $display("FAIL rebal_en_rise_edge: got %0d expected 32784", k_en);
        end
        checks++;
        if (k_ro !== -1) begin
            errors++;
            $display("FAIL rebal_ro: got change=%0d expected -1", k_ro);
        end
    endtask

    // Averages 0x150,0x120,0xF0,0xC0: tot drops below 0x1C0 on the 4th strobe.
    task automatic test_dismount();
        track(12'h0C0, 12'h0C0, 40);
        checks++;
        if (k_en !== 25) begin
            errors++;
            $display("FAIL dismount_en_edge: got %0d expected 25", k_en);
        end
        checks++;
        if (k_ro !== 25) begin
            errors++;
            $display("FAIL dismount_ro_edge: got %0d expected 25", k_ro);
        end
        checks++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1) begin
            errors++;
            $display("FAIL dismount_final: got en=%b ro=%b expected en=0 ro=1", en_steer, rider_off);
        end
    endtask

    task automatic test_hysteresis();
        // tot 0x200 inside the band: no mount
        track(12'h100, 12'h100, 40);
        checks++;
        if (k_ro !== -1 || rider_off !== 1'b1) begin
            errors++;
            $display("FAIL hyst_idle_hold: got change=%0d ro=%b expected change=-1 ro=1", k_ro, rider_off);
        end
        // tot reaches exactly 0x240 on the 4th strobe
        track(12'h120, 12'h120, 40);
        checks++;
        if (k_ro !== 25 || rider_off !== 1'b0) begin
            errors++;
            $display("FAIL hyst_enter_wait: got change=%0d ro=%b expected change=25 ro=0", k_ro, rider_off);
        end
        // tot settles at exactly 0x1C0: still on board
        track(12'h0E0, 12'h0E0, 40);
        checks++;
        if (k_ro !== -1 || rider_off !== 1'b0) begin
            errors++;
            $display("FAIL hyst_wait_hold: got change=%0d ro=%b expected change=-1 ro=0", k_ro, rider_off);
        end
        // right avg floors to 0xDF on the first strobe: tot 0x1BF
        track(12'h0E0, 12'h0DF, 40);
        checks++;
        if (k_ro !== 1 || rider_off !== 1'b1) begin
            errors++;
            $display("FAIL hyst_exit_idle: got change=%0d ro=%b expected change=1 ro=1", k_ro, rider_off);
        end
    endtask

    task automatic test_reset_mid();
        track(12'h180, 12'h180, 20);
        checks++;
        if (rider_off !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre_ro: got %b expected 0", rider_off);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1) begin
            errors++;
            $display("FAIL midrst_out: got en=%b ro=%b expected en=0 ro=1", en_steer, rider_off);
        end
        // two strobes of 0x180 on cleared history: tot 0x180, stays IDLE
        track(12'h180, 12'h180, 12);
        checks++;
        if (k_ro !== -1 || rider_off !== 1'b1) begin
            errors++;
            $display("FAIL midrst_hist_clear: got change=%0d ro=%b expected change=-1 ro=1", k_ro, rider_off);
        end
    endtask

    initial begin
        rst     = 1'b1;
        ld_vld  = 1'b0;
        lft_ld  = '0;
        rght_ld = '0;
        test_reset();
        test_mount();
        test_step_off();
        test_unbalanced();
        test_timer_restart();
        test_dismount();
        test_hysteresis();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
